// File: rtl/muon_coinc_tdc_if.sv
// muon_coinc_tdc_if: hit/stop inputs and counter/TDC results of the muon coincidence TDC
interface muon_coinc_tdc_if #(
  parameter int NUM_CH     = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int TIME_WIDTH = 16
);
  logic [NUM_CH-1:0]           hit;
  logic                        stop;
  logic                        clear;
  logic [NUM_CH*CNT_WIDTH-1:0] ch_counts;
  logic [CNT_WIDTH-1:0]        coinc_count;
  logic [CNT_WIDTH-1:0]        decay_count;
  logic [CNT_WIDTH-1:0]        timeout_count;
  logic                        coincidence;
  logic [TIME_WIDTH-1:0]       time_measurement;
  logic                        tdc_valid;
  logic                        busy;
  modport master (
    output hit, stop, clear,
    input  ch_counts, coinc_count, decay_count, timeout_count,
           coincidence, time_measurement, tdc_valid, busy
  );
  modport slave (
    input  hit, stop, clear,
    output ch_counts, coinc_count, decay_count, timeout_count,
           coincidence, time_measurement, tdc_valid, busy
  );
endinterface

// File: rtl/muon_coinc_tdc.sv
// muon_coinc_tdc: majority coincidence of scintillator hits, decay-time TDC and event counters
module muon_coinc_tdc #(
  parameter int NUM_CH         = 3,
  parameter int MAJORITY       = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int TIME_WIDTH     = 16,
  parameter int WINDOW_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 660
) (
  input logic clk,
  input logic reset,
  muon_coinc_tdc_if.slave bus
);
  localparam int WCW = $clog2(WINDOW_CYCLES + 1);
  localparam int HCW = $clog2(HOLDOFF_CYCLES + 1);
  typedef enum logic [1:0] {C_IDLE, C_WINDOW, C_HOLDOFF} cstate_t;
  typedef enum logic {T_IDLE, T_MEASURE} tstate_t;
  cstate_t cs, cs_n;
  tstate_t ts, ts_n;
  logic [NUM_CH-1:0] hit_q, edges, mask, mask_n, merged;
  logic stop_q, stop_edge;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [HCW-1:0] hcnt, hcnt_n;
  logic [TIME_WIDTH-1:0] timer, timer_n, elapsed;
  logic coinc_n, valid_n, timeout_n, major;
  assign edges     = bus.hit & ~hit_q;
  assign stop_edge = bus.stop & ~stop_q;
  assign merged    = mask | edges;
  assign major     = $countones(merged) >= MAJORITY;
  assign elapsed   = timer + 1'b1;
  assign bus.busy  = ts == T_MEASURE;
  always_comb begin
    cs_n    = cs;
    mask_n  = mask;
    wcnt_n  = wcnt;
    hcnt_n  = hcnt;
    coinc_n = 1'b0;
    case (cs)
      C_HOLDOFF: begin
        hcnt_n = hcnt + 1'b1;
        if (hcnt >= HCW'(HOLDOFF_CYCLES - 1)) begin
          cs_n   = C_IDLE;
          hcnt_n = '0;
        end
      end
      default: begin
        if (major) begin
          coinc_n = 1'b1;
          cs_n    = C_HOLDOFF;
          mask_n  = '0;
          wcnt_n  = '0;
          hcnt_n  = '0;
        end else if (cs == C_WINDOW) begin
          mask_n = merged;
          wcnt_n = wcnt + 1'b1;
          if (wcnt >= WCW'(WINDOW_CYCLES - 1)) begin
            cs_n   = C_IDLE;
            mask_n = '0;
            wcnt_n = '0;
          end
        end else if (|edges) begin
          cs_n   = C_WINDOW;
          mask_n = edges;
          wcnt_n = WCW'(1);
        end
      end
    endcase
  end
  // a stop and a fresh coincidence on the same edge report first, then re-arm
  always_comb begin
    ts_n      = ts;
    timer_n   = timer;
    valid_n   = 1'b0;
    timeout_n = 1'b0;
    if (ts == T_MEASURE) begin
      timer_n = elapsed;
      if (stop_edge) begin
        valid_n = 1'b1;
        ts_n    = coinc_n ? T_MEASURE : T_IDLE;
        timer_n = '0;
      end else if (coinc_n) begin
        timer_n = '0;
      end else if (elapsed == TIME_WIDTH'(TIMEOUT_CYCLES)) begin
        timeout_n = 1'b1;
        ts_n      = T_IDLE;
        timer_n   = '0;
      end
    end else if (coinc_n) begin
      ts_n    = T_MEASURE;
      timer_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q                <= '0;
      stop_q               <= 1'b0;
      cs                   <= C_IDLE;
      ts                   <= T_IDLE;
      mask                 <= '0;
      wcnt                 <= '0;
      hcnt                 <= '0;
      timer                <= '0;
      bus.coincidence      <= 1'b0;
      bus.tdc_valid        <= 1'b0;
      bus.ch_counts        <= '0;
      bus.coinc_count      <= '0;
      bus.decay_count      <= '0;
      bus.timeout_count    <= '0;
      bus.time_measurement <= '0;
    end else begin
      hit_q           <= bus.hit;
      stop_q          <= bus.stop;
      cs              <= cs_n;
      ts              <= ts_n;
      mask            <= mask_n;
      wcnt            <= wcnt_n;
      hcnt            <= hcnt_n;
      timer           <= timer_n;
      bus.coincidence <= coinc_n;
      bus.tdc_valid   <= valid_n & ~bus.clear;
      if (bus.clear) begin
        bus.ch_counts        <= '0;
        bus.coinc_count      <= '0;
        bus.decay_count      <= '0;
        bus.timeout_count    <= '0;
        bus.time_measurement <= '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++)
          bus.ch_counts[i*CNT_WIDTH +: CNT_WIDTH] <=
            bus.ch_counts[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(edges[i]);
        bus.coinc_count   <= bus.coinc_count + CNT_WIDTH'(coinc_n);
        bus.decay_count   <= bus.decay_count + CNT_WIDTH'(valid_n);
        bus.timeout_count <= bus.timeout_count + CNT_WIDTH'(timeout_n);
        if (valid_n) bus.time_measurement <= elapsed;
      end
    end
  end
endmodule

// File: doc/muon_coinc_tdc.md
MUON_COINC_TDC -- requirements
Module: muon_coinc_tdc

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of scintillator hit channels (2..8).
REQ-002 SHALL have parameter MAJORITY, default 2, minimum distinct channels for a coincidence (1..NUM_CH).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of every event counter.
REQ-004 SHALL have parameter TIME_WIDTH, default 16, width of decay-time result.
REQ-005 SHALL have parameters WINDOW_CYCLES (default 4), HOLDOFF_CYCLES (default 8) and TIMEOUT_CYCLES (default 660), all ≥1; TIMEOUT_CYCLES < 2^TIME_WIDTH.
REQ-006 SHALL have one clock and a synchronous active-high reset: clk input 1 (100 MHz system clock); reset input 1 (synchronous, active-high).
REQ-007 hit  input  NUM_CH  debounced, clk-synchronous channel levels.
REQ-008 stop  input  1  debounced, clk-synchronous decay/stop level.
REQ-009 clear  input  1  synchronous counter clear.
REQ-010 ch_counts  output  NUM_CH*CNT_WIDTH  per-channel edge counts, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-011 coinc_count  output  CNT_WIDTH  coincidences detected.
REQ-012 decay_count / timeout_count  output  CNT_WIDTH each  valid measurements / aborted measurements.
REQ-013 coincidence  output  1  one-cycle pulse per coincidence.
REQ-014 time_measurement  output  TIME_WIDTH  last valid decay time in clk cycles (held).
REQ-015 tdc_valid  output  1  one-cycle pulse when time_measurement updates; busy  output  1  high while measuring.

Function
REQ-016 Rising edge on any input SHALL be input high at clock edge k and low at edge k-1 (previous-sample register, reset 0).
REQ-017 Channel counter i SHALL increment at edge k on a hit[i] rising edge; all counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-018 Coincidence FSM SHALL have states IDLE, WINDOW, HOLDOFF; internal mask NUM_CH bits, window counter.
REQ-019 In IDLE or WINDOW at edge k, with m = mask | edges: if popcount(m) ≥ MAJORITY, coincidence SHALL be high the cycle after edge k, coinc_count SHALL increment at edge k, mask cleared, FSM to HOLDOFF.
REQ-020 IDLE with edges but popcount < MAJORITY SHALL go to WINDOW, mask = edges, window count = 1.
REQ-021 WINDOW without majority SHALL OR edges into mask and increment window count; at count reaching WINDOW_CYCLES it SHALL return to IDLE with mask cleared (no coincidence).
REQ-022 HOLDOFF SHALL last HOLDOFF_CYCLES edges then return to IDLE; edges in HOLDOFF SHALL still increment channel counters but SHALL NOT form coincidences.
REQ-023 TDC FSM SHALL have states IDLE, MEASURE; busy = (state == MEASURE).
REQ-024 A coincidence at edge k SHALL enter MEASURE with start reference k (timer 0).
REQ-025 Stop rising edge at edge m in MEASURE SHALL load time_measurement = m−k, pulse tdc_valid next cycle, increment decay_count, return to IDLE.
REQ-026 If no stop edge by edge k+TIMEOUT_CYCLES, TDC SHALL return to IDLE at that edge, increment timeout_count, leave time_measurement unchanged; stop edge at exactly k+TIMEOUT_CYCLES SHALL win (result TIMEOUT_CYCLES).
REQ-027 Stop edges in TDC IDLE, including at the coincidence edge k itself, SHALL be ignored.
REQ-028 New coincidence at edge m while MEASURE and no stop: timer SHALL restart with reference m, no result, no count change.
REQ-029 New coincidence and stop edge at same edge m in MEASURE: result m−k SHALL be reported, then measurement restarts with reference m.
REQ-030 clear SHALL zero ch_counts, coinc_count, decay_count, timeout_count, time_measurement only; events at that edge are discarded from counters; FSMs unaffected.

Reset
REQ-031 reset SHALL dominate clear and all events; at edge with reset high all counters, time_measurement, masks, timers, edge registers = 0, both FSMs IDLE, coincidence/tdc_valid/busy = 0.
REQ-032 reset mid-measurement SHALL abort without incrementing any counter or pulsing tdc_valid.

Verification
REQ-033 Defaults: hit[0] rises edge 10, hit[1] edge 12 -> coincidence high after edge 12, coinc_count=1, ch_counts ch0=1 ch1=1.
REQ-034 hit[0] edge 10, hit[1] edge 15 (window 4) -> no coincidence, coinc_count=0, ch counts 1 each.
REQ-035 Coincidence at edge 20, stop rises edge 120 -> tdc_valid after edge 120, time_measurement=100, decay_count=1.
REQ-036 Coincidence at edge 20, no stop -> busy falls at edge 680, timeout_count=1, time_measurement unchanged; stop at edge 680 instead -> time_measurement=660.
REQ-037 Coincidence edge 20, second coincidence edge 50 with stop edge 50, stop edge 80 -> results 30 then 30, decay_count=2.
REQ-038 Drive 65536 hit[2] edges -> ch2 count wraps to 0; assert reset mid-measurement -> all outputs 0, busy 0, no tdc_valid.
